dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache placed between the CPU load/store path and the 128-bit-block main memory.
- Serves 32-bit word requests on a 10-bit byte address.
- On a miss, writes a dirty victim block back and fetches the missing block over the memory's combinational block interface.
- Holds 4 lines of 4 words each (64 bytes).

Parameters:
- ADDR_W, 10, byte address width (fixed by the memory interface).
- NUM_LINES, 4, cache lines; index width = log2(NUM_LINES) = 2.
- WORDS_PER_LINE, 4, 32-bit words per line (matches the 128-bit memory block).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present; held until done.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  10  byte address; [1:0] ignored.
- req_wdata  in  32  store data.
- done  out  1  one-cycle pulse; request complete.
- rdata  out  32  load data; valid in the done cycle, held afterwards.
- mem_read_write  out  1  1 = write block to memory.
- mem_address  out  10  block address; [3:0] are always 0.
- mem_write_data  out  128  victim block.
- mem_read_data  in  128  block from memory (combinational).
- hit_cnt  out  CNT_W  completed hits, wrapping.
- miss_cnt  out  CNT_W  misses, wrapping.

Behaviour:
- Address split:
  - byte offset [1:0]
  - word offset [3:2]
  - index [5:4]
  - tag [9:6]
- Block packing, both directions: word w occupies bits [32w+31:32w].
- Per-line state: valid, dirty, 4-bit tag, 128-bit data.
- Reset (synchronous) clears:
  - all valid and dirty bits; tags and data are don't-care
  - state to IDLE
  - done = 0, rdata = 0, mem_read_write = 0, mem_address = 0, hit_cnt = 0, miss_cnt = 0
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
  - IDLE: if req_valid, latch addr, we and wdata, then go to COMPARE. Otherwise stay.
  - COMPARE, hit (valid and tag match):
    - load: rdata <= selected word.
    - store: write the word into the line and set dirty.
    - done = 1 for this cycle, hit_cnt++, go to IDLE.
  - COMPARE, miss: miss_cnt++. Go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
  - WRITEBACK (exactly one cycle):
    - mem_read_write = 1, mem_address = {victim tag, index, 4'b0}, mem_write_data = victim data.
    - Go to ALLOCATE.
  - ALLOCATE (exactly one cycle):
    - mem_read_write = 0, mem_address = {req tag, index, 4'b0}.
    - Capture mem_read_data into the line; set valid = 1, dirty = 0, tag = req tag.
    - Go to COMPARE; this re-check is guaranteed to hit.
- Latency from the IDLE accept cycle to the done cycle, inclusive:
  - hit: 2 cycles
  - clean miss: 4 cycles
  - dirty miss: 5 cycles
  - One miss increments miss_cnt once and hit_cnt once (on the re-check).
- mem_read_write is decoded from the state register only; no combinational path from req_* to it.
- mem_read_write is 0 in every state except WRITEBACK.
- req_* changes while not in IDLE are ignored; the latched copy is used.
- req_valid still high in the cycle after done is accepted as a new request.
- Reset in any state aborts the request:
  - no done pulse
  - mem_read_write = 0 from the next edge
  - a line half-allocated at reset is invalid after reset
- Counters wrap at 2^CNT_W.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, COMPARE, WRITEBACK, ALLOCATE}
  - field-width constants (TAG_W = 4, IDX_W = 2, WOFF_W = 2, BLOCK_W = 128)
  - address-slicing helper functions
- Sub-module cache_line_array:
  - tag/valid/dirty/data storage
  - one combinational read port
  - one synchronous port for word write and block fill, with reset clearing valid/dirty
- The FSM and counters stay in dm_cache_ctrl.

Test Plan:
1. Reset, memory block 0x040 preloaded with words {0x11111111, 0x22222222, 0x33333333, 0x44444444}; load 0x044 -> done on cycle 4, rdata = 0x22222222, miss_cnt = 1, hit_cnt = 1, mem_read_write never 1.
2. Then load 0x04C -> done on cycle 2, rdata = 0x44444444, miss_cnt = 1, hit_cnt = 2.
3. Store 0xDEADBEEF to 0x044 -> done on cycle 2; memory word 0x044 still 0x22222222; a following load of 0x044 returns 0xDEADBEEF.
4. Load 0x144 (same index, tag 0x5) -> exactly one cycle with mem_read_write = 1, mem_address = 0x040, mem_write_data[63:32] = 0xDEADBEEF; done on cycle 5; rdata = memory word 0x144.
5. Start a load of 0x284 (clean miss), assert reset during ALLOCATE -> no done pulse, counters 0; a subsequent load of 0x284 misses again (4 cycles).
6. Drive a different req_addr/req_we mid-miss -> the original request completes with the original address; the new values take effect only when sampled in IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, field widths and address-slicing helpers for the direct-mapped cache.
// The controller and the line array both import this package.
package cache_pkg;

  localparam int ADDR_W         = 10;
  localparam int NUM_LINES      = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int TAG_W          = 4;
  localparam int IDX_W          = 2;
  localparam int WOFF_W         = 2;
  localparam int BLOCK_W        = WORDS_PER_LINE * WORD_W;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [WOFF_W-1:0]  woff_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[ADDR_W-TAG_W-1 -: IDX_W];
  endfunction

  function automatic woff_t addr_woff(input addr_t a);
    return a[2 +: WOFF_W];
  endfunction

  // Block-aligned memory address: the low nibble is always zero.
  function automatic addr_t block_addr(input tag_t t, input idx_t i);
    return {t, i, {(ADDR_W-TAG_W-IDX_W){1'b0}}};
  endfunction

  function automatic word_t get_word(input block_t b, input woff_t w);
    return b[{w, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage for the cache: one combinational read port and one
// synchronous write port used for either a single-word store or a whole-block fill.
module cache_line_array
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   i_reset,
  input  idx_t   i_idx,
  input  logic   i_word_we,
  input  woff_t  i_woff,
  input  word_t  i_wdata,
  input  logic   i_fill_we,
  input  tag_t   i_fill_tag,
  input  block_t i_fill_data,
  output logic   o_valid,
  output logic   o_dirty,
  output tag_t   o_tag,
  output block_t o_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  tag_t                 r_tag  [NUM_LINES];
  block_t               r_data [NUM_LINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  // Reset wins over a fill, so a line caught mid-allocation comes out invalid.
  // NOTE: non-blocking (<=) in every clocked block so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid gates their meaning.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_word_we) begin
      r_data[i_idx][{i_woff, 5'b0} +: WORD_W] <= i_wdata;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: 4 lines x 4 words,
// 10-bit byte address, 128-bit block interface to a combinational main memory.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               done,
  output logic [WORD_W-1:0]  rdata,
  output logic               mem_read_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_write_data,
  input  logic [BLOCK_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  state_t           r_state;
  addr_t            r_addr;
  logic             r_we;
  word_t            r_wdata;
  word_t            r_rdata;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  state_t w_next_state;
  tag_t   w_req_tag;
  idx_t   w_idx;
  woff_t  w_woff;
  logic   w_line_valid;
  logic   w_line_dirty;
  tag_t   w_line_tag;
  block_t w_line_data;
  logic   w_hit;
  logic   w_word_we;
  logic   w_fill_we;
  logic   w_unused_byte_off;

  assign w_req_tag         = addr_tag(r_addr);
  assign w_idx             = addr_idx(r_addr);
  assign w_woff            = addr_woff(r_addr);
  assign w_hit             = w_line_valid && (w_line_tag == w_req_tag);
  assign w_unused_byte_off = ^r_addr[1:0];

  cache_line_array u_lines (
    .clk         (clk),
    .i_reset     (reset),
    .i_idx       (w_idx),
    .i_word_we   (w_word_we),
    .i_woff      (w_woff),
    .i_wdata     (r_wdata),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (w_req_tag),
    .i_fill_data (mem_read_data),
    .o_valid     (w_line_valid),
    .o_dirty     (w_line_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_line_data)
  );

  // Memory-side outputs depend only on r_state and latched/stored values, never on req_*.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    done           = 1'b0;
    mem_read_write = 1'b0;
    mem_address    = '0;
    w_word_we      = 1'b0;
    w_fill_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_next_state = COMPARE;
      end
      COMPARE: begin
        if (w_hit) begin
          done         = !reset;
          w_word_we    = r_we;
          w_next_state = IDLE;
        end else if (w_line_valid && w_line_dirty) begin
          w_next_state = WRITEBACK;
        end else begin
          w_next_state = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_read_write = 1'b1;
        mem_address    = block_addr(w_line_tag, w_idx);
        w_next_state   = ALLOCATE;
      end
      ALLOCATE: begin
        mem_address  = block_addr(w_req_tag, w_idx);
        w_fill_we    = 1'b1;
        w_next_state = COMPARE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
      end
      if (r_state == COMPARE) begin
        if (w_hit) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
          if (!r_we) r_rdata <= get_word(w_line_data, w_woff);
        end else begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
    end
  end

  // Load data is forwarded in the done cycle and held in r_rdata afterwards.
  assign rdata          = (done && !r_we) ? get_word(w_line_data, w_woff) : r_rdata;
  assign mem_write_data = w_line_data;
  assign hit_cnt        = r_hit_cnt;
  assign miss_cnt       = r_miss_cnt;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: the driver predicts each response from a flat
// word-addressed memory image plus per-line residency, and a monitor checks DUT outputs.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_we;
  logic [9:0]   req_addr;
  logic [31:0]  req_wdata;
  logic         done;
  logic [31:0]  rdata;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .done           (done),
    .rdata          (rdata),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  // Main memory: 64 blocks, combinational read, write on the clock edge.
  logic [127:0] phys     [64];
  logic [127:0] init_blk [64];
  bit           mem_init;

  assign mem_read_data = phys[mem_address[9:4]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) phys[i] <= init_blk[i];
    end else if (mem_read_write) begin
      phys[mem_address[9:4]] <= mem_write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          lat;
    int          start;
    int          hits;
    int          misses;
  } exp_t;

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural word memory plus which block each line holds.
  logic [31:0] arch [256];
  bit          m_valid [4];
  bit          m_dirty [4];
  logic [3:0]  m_tag   [4];
  int          m_hits;
  int          m_misses;

  function automatic logic [127:0] arch_block(input int blk);
    return {arch[blk*4+3], arch[blk*4+2], arch[blk*4+1], arch[blk*4]};
  endfunction

  task automatic model_reset_from_phys();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
    for (int i = 0; i < 256; i++) arch[i] = phys[i/4][(i%4)*32 +: 32];
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the done cycle.
  task automatic issue(input logic [9:0] addr, input logic we, input logic [31:0] wdata,
                       input bit scramble);
    exp_t       e;
    int         idx = int'(addr[5:4]);
    int         wa  = int'(addr[9:2]);
    logic [3:0] tag = addr[9:6];
    logic [1:0] idx2 = addr[5:4];
    bit         got = 0;
    e.we    = we;
    e.start = cyc;
    e.rdata = '0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        wb_q.push_back('{addr: {m_tag[idx], idx2, 4'b0000},
                         data: arch_block(int'({m_tag[idx], idx2}))});
        e.lat = 5;
      end else begin
        e.lat = 4;
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tag;
    end else begin
      e.lat = 2;
    end
    m_hits++;
    if (we) begin
      arch[wa]     = wdata;
      m_dirty[idx] = 1;
    end else begin
      e.rdata = arch[wa];
    end
    e.hits   = m_hits;
    e.misses = m_misses;
    exp_q.push_back(e);

    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (scramble && i > 0) begin
        req_addr  = 10'($urandom);
        req_we    = 1'($urandom);
        req_wdata = $urandom;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    exp_t e;
    wb_t  w;
    bit   cnt_pend = 0;
    int   pend_hits = 0;
    int   pend_misses = 0;
    forever begin
      @(negedge clk);
      if (cnt_pend) begin
        check("hit_cnt", hit_cnt, pend_hits);
        check("miss_cnt", miss_cnt, pend_misses);
        cnt_pend = 0;
      end
      if (!reset && done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("latency", cyc - e.start + 1, e.lat);
          if (!e.we) check("rdata", rdata, e.rdata);
          pend_hits   = e.hits;
          pend_misses = e.misses;
          cnt_pend    = 1;
        end
      end
      if (!reset && mem_read_write) begin
        if (wb_q.size() == 0) check("unexpected_writeback", 1, 0);
        else begin
          w = wb_q.pop_front();
          check("wb_addr", mem_address, w.addr);
          check("wb_data", mem_write_data, w.data);
        end
      end
    end
  end

  initial begin
    logic [9:0] a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_init  = 1;
    for (int i = 0; i < 64; i++) init_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    init_blk[4] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    repeat (3) @(posedge clk);
    #1;
    model_reset_from_phys();
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_rw", mem_read_write, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    mem_init = 0;
    reset    = 1'b0;

    // Clean miss, then a hit in the same block, then store hit and read-back.
    issue(10'h044, 1'b0, 32'h0, 0);
    issue(10'h04C, 1'b0, 32'h0, 0);
    issue(10'h044, 1'b1, 32'hDEADBEEF, 0);
    check("mem_044_untouched", phys[4][63:32], 32'h22222222);
    issue(10'h044, 1'b0, 32'h0, 0);

    // Conflict miss on a dirty line forces a writeback of block 0x040.
    issue(10'h144, 1'b0, 32'h0, 0);
    check("wb_landed", phys[4][63:32], 32'hDEADBEEF);

    // Clean miss aborted by reset while allocating.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h284;
    req_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("alloc_addr", mem_address, 10'h280);
    check("alloc_rw", mem_read_write, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    model_reset_from_phys();
    check("abort_hit_cnt", hit_cnt, 0);
    check("abort_miss_cnt", miss_cnt, 0);
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 0);
    check("abort_mem_rw", mem_read_write, 0);
    issue(10'h284, 1'b0, 32'h0, 0);

    // Request inputs wiggle while the controller is busy.
    issue(10'h3C8, 1'b0, 32'h0, 1);
    issue(10'h0D4, 1'b1, $urandom, 1);
    issue(10'h3C8, 1'b0, 32'h0, 1);

    // Randomised traffic over three tags so hits, clean and dirty misses all occur.
    repeat (300) begin
      a      = 10'($urandom);
      a[9:6] = 4'($urandom_range(0, 2));
      issue(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
